formula_nested_sqrt_fsm: RTL and testbench

FORMULA_NESTED_SQRT_FSM -- requirements
Module: formula_nested_sqrt_fsm

---
 rtl/formula_pkg.sv | 19 +
 rtl/formula_nested_sqrt_fsm.sv | 127 ++++++++++++
 tb/tb_formula_nested_sqrt_fsm.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/formula_pkg.sv
// Shared types for the nested/summed isqrt formula sequencer.
package formula_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        MODE_NESTED = 1'b0,
        MODE_SUM    = 1'b1
    } mode_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/formula_nested_sqrt_fsm.sv
// Sequences N terms through one external isqrt, either nested
// (isqrt(a0 + isqrt(a1 + ...))) or as a sum of independent roots.
module formula_nested_sqrt_fsm
    import formula_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arg_vld,
    output logic             arg_rdy,
    input  logic             mode,
    input  logic [N*W-1:0]   args,
    output logic             res_vld,
    output logic [W-1:0]     res,
    output logic             isqrt_x_vld,
    output logic [W-1:0]     isqrt_x,
    input  logic             isqrt_y_vld,
    input  logic [W/2-1:0]   isqrt_y
);

    localparam int KW = idx_width(N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    state_t        st;
    state_t        st_nxt;
    mode_t         mode_q;
    logic [W-1:0]  a_q [N];
    logic [KW-1:0] k;
    logic [W-1:0]  acc;

    logic          accept;
    logic          y_take;
    logic          last;
    logic [W-1:0]  y_ext;
    logic [W-1:0]  acc_nxt;
    logic [W-1:0]  operand;

    assign accept = (st == ST_IDLE) && arg_vld;
    assign y_take = (st == ST_WAIT) && isqrt_y_vld;
    assign last   = (k == '0);
    assign y_ext  = {{(W/2){1'b0}}, isqrt_y};

    // Nested mode keeps only the latest root; sum mode accumulates.
    assign acc_nxt = (mode_q == MODE_SUM) ? acc + y_ext : y_ext;

    always_comb begin
        operand = a_q[k];
        if (mode_q == MODE_NESTED && k != K_LAST) begin
            operand = a_q[k] + acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= ST_IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt = st;
        unique case (st)
            ST_IDLE: begin
                if (arg_vld) begin
                    st_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                st_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (isqrt_y_vld) begin
                    st_nxt = last ? ST_IDLE : ST_ISSUE;
                end
            end
            default: begin
                st_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        arg_rdy     = (st == ST_IDLE);
        isqrt_x_vld = (st == ST_ISSUE);
        isqrt_x     = '0;
        if (st == ST_ISSUE) begin
            isqrt_x = operand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k       <= '0;
            acc     <= '0;
            res     <= '0;
            res_vld <= 1'b0;
            mode_q  <= MODE_NESTED;
        end else begin
            res_vld <= y_take && last;
            if (accept) begin
                k      <= K_LAST;
                acc    <= '0;
                mode_q <= mode_t'(mode);
            end else if (y_take) begin
                acc <= acc_nxt;
                if (last) begin
                    res <= acc_nxt;
                end else begin
                    k <= k - 1'b1;
                end
            end
        end
    end

    // Operands are data-only; the FSM never reads them outside a run.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                a_q[i] <= args[i*W +: W];
            end
        end
    end

endmodule

// File: tb/tb_formula_nested_sqrt_fsm.sv
// Bench for formula_nested_sqrt_fsm: N=3 and N=1 builds, each fed
// by a latency-4 behavioural isqrt.
module tb_formula_nested_sqrt_fsm;

    localparam int W = 32;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int total_cnt = 0;

    // N=3 instance signals
    logic          arg_vld3 = 1'b0;
    logic          arg_rdy3;
    logic          mode3 = 1'b0;
    logic [3*W-1:0] args3 = '0;
    logic          res_vld3;
    logic [W-1:0]  res3;
    logic          x_vld3;
    logic [W-1:0]  x3;
    logic          y_vld3;
    logic [W/2-1:0] y3;

    // N=1 instance signals
    logic          arg_vld1 = 1'b0;
    logic          arg_rdy1;
    logic          mode1 = 1'b0;
    logic [W-1:0]  args1 = '0;
    logic          res_vld1;
    logic [W-1:0]  res1;
    logic          x_vld1;
    logic [W-1:0]  x1;
    logic          y_vld1;
    logic [W/2-1:0] y1;

    formula_nested_sqrt_fsm #(.W(W), .N(3)) dut3 (
        .clk(clk), .rst(rst),
        .arg_vld(arg_vld3), .arg_rdy(arg_rdy3),
        .mode(mode3), .args(args3),
        .res_vld(res_vld3), .res(res3),
        .isqrt_x_vld(x_vld3), .isqrt_x(x3),
        .isqrt_y_vld(y_vld3), .isqrt_y(y3)
    );

    formula_nested_sqrt_fsm #(.W(W), .N(1)) dut1 (
        .clk(clk), .rst(rst),
        .arg_vld(arg_vld1), .arg_rdy(arg_rdy1),
        .mode(mode1), .args(args1),
        .res_vld(res_vld1), .res(res1),
        .isqrt_x_vld(x_vld1), .isqrt_x(x1),
        .isqrt_y_vld(y_vld1), .isqrt_y(y1)
    );

    function automatic logic [15:0] isqrt_f(input logic [31:0] v);
        logic [15:0] r;
        logic [15:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | 16'(1 << b);
            if (longint'(t) * longint'(t) <= longint'(v)) r = t;
        end
        return r;
    endfunction

    function automatic logic [31:0] ref3(input logic m,
                                         input logic [31:0] a0,
                                         input logic [31:0] a1,
                                         input logic [31:0] a2);
        logic [31:0] v;
        if (m) begin
            v = 32'(isqrt_f(a0)) + 32'(isqrt_f(a1)) + 32'(isqrt_f(a2));
        end else begin
            v = 32'(isqrt_f(a2));
            v = 32'(isqrt_f(a1 + v));
            v = 32'(isqrt_f(a0 + v));
        end
        return v;
    endfunction

    // External isqrt models: fixed latency L, never reset.
    logic [L-1:0] pv3 = '0;
    logic [L-1:0] pv1 = '0;
    logic [15:0]  pd3 [L];
    logic [15:0]  pd1 [L];
    always @(posedge clk) begin
        pv3 <= {pv3[L-2:0], x_vld3};
        pv1 <= {pv1[L-2:0], x_vld1};
        pd3[0] <= isqrt_f(x3);
        pd1[0] <= isqrt_f(x1);
        for (int i = 1; i < L; i++) begin
            pd3[i] <= pd3[i-1];
            pd1[i] <= pd1[i-1];
        end
    end
    assign y_vld3 = pv3[L-1];
    assign y3     = pd3[L-1];
    assign y_vld1 = pv1[L-1];
    assign y1     = pd1[L-1];

    // Observation queues, sampled mid-cycle.
    logic [31:0] r3_q[$];
    int          r3_t[$];
    logic        r3_rdy[$];
    int          acc3_t[$];
    logic [31:0] ops3[$];
    int          xn3 = 0;
    int          xbad = 0;
    logic [31:0] r1_q[$];
    int          r1_t[$];
    logic        r1_rdy[$];
    int          acc1_t[$];

    always @(negedge clk) begin
        if (res_vld3) begin
            r3_q.push_back(res3);
            r3_t.push_back(cyc);
            r3_rdy.push_back(arg_rdy3);
        end
        if (x_vld3) begin
            xn3 <= xn3 + 1;
            ops3.push_back(x3);
        end else if (x3 !== '0 || x1 !== '0) begin
            xbad <= xbad + 1;
        end
        if (!rst && arg_vld3 && arg_rdy3) acc3_t.push_back(cyc);
        if (res_vld1) begin
            r1_q.push_back(res1);
            r1_t.push_back(cyc);
            r1_rdy.push_back(arg_rdy1);
        end
        if (!rst && arg_vld1 && arg_rdy1) acc1_t.push_back(cyc);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear3();
        r3_q.delete();
        r3_t.delete();
        r3_rdy.delete();
        acc3_t.delete();
        ops3.delete();
    endtask

    task automatic submit3(input logic m, input logic [31:0] a0,
                           input logic [31:0] a1, input logic [31:0] a2);
        int guard;
        mode3 = m;
        args3 = {a2, a1, a0};
        arg_vld3 = 1'b1;
        guard = 0;
        while (!arg_rdy3 && guard < 100) begin
            tick();
            guard++;
        end
        tick();
        arg_vld3 = 1'b0;
    endtask

    task automatic wait_res3(input int n);
        int guard;
        guard = 0;
        while (r3_q.size() < n && guard < 80) begin
            tick();
            guard++;
        end
        tick(8);
    endtask

    function automatic logic [31:0] first3();
        return (r3_q.size() > 0) ? r3_q[0] : 32'hDEAD_BEEF;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        total_cnt++;
        if (arg_rdy3 !== 1'b1 || arg_rdy1 !== 1'b1)
            $display("FAIL reset_rdy got %b/%b want 1/1", arg_rdy3, arg_rdy1);
        else pass_cnt++;
        total_cnt++;
        if (res_vld3 !== 1'b0 || res_vld1 !== 1'b0)
            $display("FAIL reset_res_vld got %b/%b want 0/0", res_vld3, res_vld1);
        else pass_cnt++;
        total_cnt++;
        if (res3 !== '0 || res1 !== '0)
            $display("FAIL reset_res got %0h/%0h want 0/0", res3, res1);
        else pass_cnt++;
        total_cnt++;
        if (x_vld3 !== 1'b0 || x_vld1 !== 1'b0)
            $display("FAIL reset_x_vld got %b/%b want 0/0", x_vld3, x_vld1);
        else pass_cnt++;
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_nested();
        int x0;
        int lat;
        clear3();
        x0 = xn3;
        submit3(1'b0, 13, 5, 16);
        wait_res3(1);
        total_cnt++;
        if (r3_q.size() != 1)
            $display("FAIL nested_count got %0d want 1", r3_q.size());
        else pass_cnt++;
        total_cnt++;
        if (first3() !== 32'd4)
            $display("FAIL nested_res got %0d want 4", first3());
        else pass_cnt++;
        lat = (r3_t.size() > 0 && acc3_t.size() > 0) ? r3_t[0] - acc3_t[0] : -1;
        total_cnt++;
        if (lat != 3 * (L + 1) + 1)
            $display("FAIL nested_latency got %0d want %0d", lat, 3 * (L + 1) + 1);
        else pass_cnt++;
        total_cnt++;
        if (xn3 - x0 != 3)
            $display("FAIL nested_requests got %0d want 3", xn3 - x0);
        else pass_cnt++;
        total_cnt++;
        if (r3_rdy.size() != 1 || r3_rdy[0] !== 1'b1)
            $display("FAIL nested_rdy_at_res got %0d entries want rdy=1", r3_rdy.size());
        else pass_cnt++;
    endtask

    task automatic test_sum();
        clear3();
        submit3(1'b1, 4, 9, 16);
        wait_res3(1);
        total_cnt++;
        if (r3_q.size() != 1)
            $display("FAIL sum_count got %0d want 1", r3_q.size());
        else pass_cnt++;
        total_cnt++;
        if (first3() !== 32'd9)
            $display("FAIL sum_res got %0d want 9", first3());
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [31:0] op1;
        clear3();
        submit3(1'b0, 0, 32'hFFFF_FFFF, 1);
        wait_res3(1);
        op1 = (ops3.size() > 1) ? ops3[1] : 32'hDEAD_BEEF;
        total_cnt++;
        if (op1 !== 32'd0)
            $display("FAIL wrap_operand got %0h want 0", op1);
        else pass_cnt++;
        total_cnt++;
        if (first3() !== 32'd0 || r3_q.size() != 1)
            $display("FAIL wrap_res got %0h (%0d results) want 0 (1)", first3(), r3_q.size());
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] a [3];
        logic        m;
        logic [31:0] exp;
        int          bad;
        bad = 0;
        for (int it = 0; it < 16; it++) begin
            clear3();
            m = 1'($urandom);
            for (int j = 0; j < 3; j++)
                a[j] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 400));
            exp = ref3(m, a[0], a[1], a[2]);
            submit3(m, a[0], a[1], a[2]);
            for (int c = 0; c < 10; c++) begin
                args3 = {$urandom, $urandom, $urandom};
                mode3 = 1'($urandom);
                arg_vld3 = 1'($urandom);
                tick();
            end
            arg_vld3 = 1'b0;
            wait_res3(1);
            total_cnt++;
            if (r3_q.size() != 1 || first3() !== exp) begin
                $display("FAIL random_%0d got %0h (%0d results) want %0h", it, first3(), r3_q.size(), exp);
                bad++;
            end else pass_cnt++;
        end
        total_cnt++;
        if (xbad != 0)
            $display("FAIL x_zero_when_idle got %0d nonzero cycles want 0", xbad);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int x0;
        int guard;
        clear3();
        x0 = xn3;
        submit3(1'b0, 100, 200, 300);
        guard = 0;
        while (xn3 - x0 < 2 && guard < 50) begin
            tick();
            guard++;
        end
        total_cnt++;
        if (xn3 - x0 < 2)
            $display("FAIL rstmid_second_req got %0d want 2", xn3 - x0);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if (arg_rdy3 !== 1'b1 || res3 !== '0)
            $display("FAIL rstmid_idle got rdy=%b res=%0h want 1/0", arg_rdy3, res3);
        else pass_cnt++;
        tick(8);
        submit3(1'b1, 4, 9, 16);
        wait_res3(1);
        total_cnt++;
        if (r3_q.size() != 1 || first3() !== 32'd9)
            $display("FAIL rstmid_res got %0d (%0d results) want 9 (1)", first3(), r3_q.size());
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int guard;
        logic [31:0] g0;
        logic [31:0] g1;
        r1_q.delete();
        r1_t.delete();
        r1_rdy.delete();
        acc1_t.delete();
        mode1 = 1'b0;
        args1 = 32'd1000000;
        arg_vld1 = 1'b1;
        guard = 0;
        while (acc1_t.size() < 2 && guard < 40) begin
            tick();
            guard++;
        end
        arg_vld1 = 1'b0;
        guard = 0;
        while (r1_q.size() < 2 && guard < 40) begin
            tick();
            guard++;
        end
        tick(4);
        total_cnt++;
        if (r1_q.size() != 2) begin
            $display("FAIL b2b_count got %0d want 2", r1_q.size());
        end else begin
            pass_cnt++;
            g0 = r1_q[0];
            g1 = r1_q[1];
            total_cnt++;
            if (g0 !== 32'd1000 || g1 !== 32'd1000)
                $display("FAIL b2b_res got %0d,%0d want 1000,1000", g0, g1);
            else pass_cnt++;
            total_cnt++;
            if (r1_rdy[0] !== 1'b1 || r1_rdy[1] !== 1'b1)
                $display("FAIL b2b_rdy got %b,%b want 1,1", r1_rdy[0], r1_rdy[1]);
            else pass_cnt++;
            total_cnt++;
            if (acc1_t.size() < 2 || acc1_t[1] != r1_t[0])
                $display("FAIL b2b_accept_cycle got %0d want %0d",
                         (acc1_t.size() > 1) ? acc1_t[1] : -1, r1_t[0]);
            else pass_cnt++;
            total_cnt++;
            if (r1_t[0] - acc1_t[0] != L + 2)
                $display("FAIL b2b_latency got %0d want %0d", r1_t[0] - acc1_t[0], L + 2);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_nested();
        test_sum();
        test_wrap();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
